// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Status encoding and default timing shared by the game blocks.
// Revision : 1.0
// ============================================================================
package game_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    // 10 ms debounce and 60 Hz frame at a 100 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_TICK_CYCLES     = 1_666_667;

    function automatic logic is_play(input logic [1:0] status);
        return status == ST_PLAY;
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/debounce.sv
`default_nettype none
// ============================================================================
// Module   : debounce
// Brief    : Two-flop synchroniser plus hold-time debouncer for one button.
// Revision : 1.0
// ============================================================================
module debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;

    // A new level is accepted only after it has held for DEBOUNCE_CYCLES edges
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level_o = level_q;

endmodule : debounce
`default_nettype wire

// File: rtl/flap_input.sv
`default_nettype none
// ============================================================================
// Module   : flap_input
// Brief    : Button conditioning, frame tick and frame-aligned flap/start.
// Revision : 1.0
// ============================================================================
module flap_input
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES     = DEF_TICK_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic [1:0]  status,
    output logic        tick,
    output logic        flap,
    output logic        start,
    output logic        up_level,
    output logic [15:0] flap_count
);

    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TK_LAST = TW'(TICK_CYCLES - 1);

    logic          level_w;
    logic          up_level_d_q;
    logic [TW-1:0] tk_cnt_q;
    logic [TW-1:0] tk_cnt_d;
    logic          pending_q;
    logic          pending_d;
    logic          tick_q;
    logic          tick_d;
    logic          flap_q;
    logic          flap_d;
    logic          start_q;
    logic          start_d;
    logic [15:0]   flap_count_q;
    logic [15:0]   flap_count_d;
    logic          press_w;
    logic          tick_edge_w;
    logic          req_w;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (up),
        .level_o (level_w)
    );

    assign press_w     = level_w & ~up_level_d_q;
    assign tick_edge_w = (tk_cnt_q == TK_LAST);
    assign req_w       = pending_q | press_w;

    // Requests gather between ticks and are routed by the status seen at the tick
    always_comb begin
        tk_cnt_d     = tick_edge_w ? '0 : tk_cnt_q + 1'b1;
        pending_d    = pending_q | press_w;
        tick_d       = 1'b0;
        flap_d       = 1'b0;
        start_d      = 1'b0;
        if (tick_edge_w) begin
            tick_d    = 1'b1;
            flap_d    = req_w & is_play(status);
            start_d   = req_w & ~is_play(status);
            pending_d = 1'b0;
        end
        flap_count_d = flap_count_q;
        if (flap_d && (flap_count_q != 16'hFFFF)) begin
            flap_count_d = flap_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_level_d_q <= 1'b0;
            tk_cnt_q     <= '0;
            pending_q    <= 1'b0;
            tick_q       <= 1'b0;
            flap_q       <= 1'b0;
            start_q      <= 1'b0;
            flap_count_q <= 16'd0;
        end else begin
            up_level_d_q <= level_w;
            tk_cnt_q     <= tk_cnt_d;
            pending_q    <= pending_d;
            tick_q       <= tick_d;
            flap_q       <= flap_d;
            start_q      <= start_d;
            flap_count_q <= flap_count_d;
        end
    end

    assign up_level   = level_w;
    assign tick       = tick_q;
    assign flap       = flap_q;
    assign start      = start_q;
    assign flap_count = flap_count_q;

endmodule : flap_input
`default_nettype wire

// File: doc/flap_input.md
# flap_input

Input conditioning stage that sits directly upstream of the game controller. It synchronises and debounces the raw `up` push-button and generates the game's frame tick. Presses are converted into at most one `flap` or `start` pulse per frame, aligned with that tick, so the controller sees clean, frame-synchronous requests. It also keeps a saturating count of flaps issued.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a new synchronised level must hold before it is accepted (10 ms at 100 MHz); legal values ≥ 2.
- `TICK_CYCLES`, default 1_666_667: frame period in clock cycles (60 Hz at 100 MHz); legal values ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `up`  in  1  raw, asynchronous, bouncing button level.
- `status`  in  2  game state from the controller (IDLE=0, PLAY=1, OVER=2, 3 treated as OVER).
- `tick`  out  1  one-cycle frame-tick pulse.
- `flap`  out  1  one-cycle flap request, only ever high together with `tick`.
- `start`  out  1  one-cycle start/restart request, only ever high together with `tick`.
- `up_level`  out  1  debounced button level.
- `flap_count`  out  16  number of flaps issued since reset; saturates at 0xFFFF.

## Operation

- **Synchroniser.** `up` passes through two flip-flops (`s1`, `s2`). Only `s2` is used downstream.
- **Debouncer.** A counter `db_cnt` is sized for `DEBOUNCE_CYCLES-1`.
  - If `s2 == up_level`: `db_cnt <= 0`.
  - Else if `db_cnt == DEBOUNCE_CYCLES-1`: `up_level <= s2` and `db_cnt <= 0`.
  - Else: `db_cnt <= db_cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `up_level`.
- **Press event.**
  - `press = up_level & ~up_level_d`, where `up_level_d` is `up_level` delayed by one register.
  - Releases generate nothing.
  - Holding the button generates exactly one press.
- **Tick counter.**
  - `tk_cnt` counts 0..`TICK_CYCLES-1` and wraps to 0.
  - The wrap edge is the "tick edge".
- **Request latch.** `pending` is a 1-bit register.
  - On a non-tick edge: `pending <= pending | press`; `tick`, `flap` and `start` are driven to 0.
  - On a tick edge, with `req = pending | press`:
    - `tick <= 1`.
    - `flap <= req & (status == PLAY)`.
    - `start <= req & (status != PLAY)`.
    - `pending <= 0`.
- **Coalescing.** Multiple presses within one frame collapse into a single request. Nothing is carried into the next frame.
- **Status sampling.** `status` is sampled only on the tick edge. If it changes mid-frame, the request is routed according to its value at the tick.
- **Flap counter.** `flap_count <= flap_count + 1` on every edge where the `flap` register is loaded with 1, unless the counter is already 0xFFFF.
- **Reset.** `rst` has priority over all other logic at every edge. It clears:
  - `s1`, `s2`, `up_level`, `up_level_d`;
  - `db_cnt`, `tk_cnt`, `pending`;
  - `tick`, `flap`, `start`, `flap_count`.
  - A press in progress is discarded. A button held through reset is seen as a new press once it is debounced after reset.

## Timing

- Reset values: every output is 0.
- First `tick` after reset deasserts: the `TICK_CYCLES`-th clock edge, counting the first edge with `rst = 0` as edge 1. Subsequent ticks follow every `TICK_CYCLES` cycles exactly.
- `up` edge to `up_level` change: 2 synchroniser cycles plus `DEBOUNCE_CYCLES` cycles, given a stable input.
- `up_level` rising to `press`: `press` is high during the cycle after `up_level` rises.
- `press` to `flap`/`start`:
  - If a tick edge falls at the end of the press cycle, the request appears at that tick.
  - Otherwise it appears at the next tick.
  - Worst-case latency is `TICK_CYCLES` cycles.
- `flap` and `start` are never high simultaneously.
- Neither is ever high while `tick` is low.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Shared package `game_pkg` holds:
  - the status encoding constants `ST_IDLE=2'd0`, `ST_PLAY=2'd1`, `ST_OVER=2'd2`, also used by the controller and the display;
  - the default timing constants.
- Sub-module `debounce` contains the synchroniser, the debouncer and the `up_level` output. It is parameterised by `DEBOUNCE_CYCLES` and is reusable for `clr`.
- The tick counter, the request latch and the flap counter stay in `flap_input`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4` and `TICK_CYCLES=10`.

- **Reset.** Hold `rst` for 3 cycles with `up=1` -> all outputs are 0 during reset. The first `tick` comes at the 10th edge after release, and `up_level` rises 6 cycles after release.
- **Bounce rejection.** Toggle `up` with 1–3-cycle pulses for 40 cycles -> `up_level` stays 0, and no `flap` or `start` occurs.
- **Single flap.** `status=PLAY`, a clean press held for 30 cycles -> exactly one `flap`, coincident with the first `tick` after `press`, and `flap_count = 1`.
- **Coalescing.** Two clean presses inside one frame -> one `flap` at that frame's tick, none at the next, and `flap_count` increments by 1.
- **Status routing.** Press while `status=IDLE`, then switch `status` to PLAY before the tick -> `flap=1`, `start=0`. Repeat with `status=OVER` held through the tick -> `start=1`, `flap=0`, and `flap_count` is unchanged.
- **Saturation and mid-frame reset.** Force `flap_count` to 0xFFFE and issue 3 flaps -> the count holds at 0xFFFF. Assert `rst` one cycle after a press -> `pending` is cleared and no `flap` occurs at the next tick.
